// File: rtl/cpu_mmio_pkg.sv
// cpu_mmio_pkg: register offsets, TCON bit positions and default base for CPU MMIO peripherals
package cpu_mmio_pkg;
    localparam logic [31:0] MMIO_BASE_ADDR = 32'h4000_0000;
    localparam logic [4:0] TIMER_TH_OFS      = 5'h00;
    localparam logic [4:0] TIMER_TL_OFS      = 5'h04;
    localparam logic [4:0] TIMER_TCON_OFS    = 5'h08;
    localparam logic [4:0] TIMER_SYSTICK_OFS = 5'h14;
    localparam int TCON_EN     = 0;
    localparam int TCON_IE     = 1;
    localparam int TCON_STATUS = 2;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: emits one tick every PRESCALE enabled cycles; clr or !en restarts the count
module tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [W-1:0] cnt;
    assign tick = en && !clr && cnt == W'(PRESCALE - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (!en || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped interval timer (TH/TL/TCON/SYSTICK) with overflow reload and level IRQ
module mmio_timer
    import cpu_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MMIO_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        IRQ
);
    logic [31:0] th, tl, systick;
    logic        en, ie, status;
    logic        in_win, sel_th, sel_tl, sel_tcon, sel_sys;
    logic        wr_th, wr_tl, wr_tcon, tcon_off, tick, ovf, set_st;
    logic [31:0] tcon;
    assign in_win   = Address[31:5] == BASE_ADDR[31:5] && Address[1:0] == 2'b00;
    assign sel_th   = in_win && Address[4:0] == TIMER_TH_OFS;
    assign sel_tl   = in_win && Address[4:0] == TIMER_TL_OFS;
    assign sel_tcon = in_win && Address[4:0] == TIMER_TCON_OFS;
    assign sel_sys  = in_win && Address[4:0] == TIMER_SYSTICK_OFS;
    assign hit      = (sel_th || sel_tl || sel_tcon || sel_sys) && (MemRead || MemWrite);
    assign wr_th    = MemWrite && sel_th;
    assign wr_tl    = MemWrite && sel_tl;
    assign wr_tcon  = MemWrite && sel_tcon;
    assign tcon     = {29'b0, status, ie, en};
    // a disabling TCON write suppresses a coincident tick and restarts the prescaler
    assign tcon_off = wr_tcon && !Write_data[TCON_EN];
    tick_divider #(.PRESCALE(PRESCALE)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (tcon_off),
        .tick  (tick)
    );
    assign ovf    = tick && tl == 32'hFFFF_FFFF;
    assign set_st = ovf && (ie || (wr_tcon && Write_data[TCON_IE]));
    assign IRQ    = ie && status;
    always_comb
        Read_data = !(MemRead && hit) ? 32'h0 :
                    sel_th   ? th   :
                    sel_tl   ? tl   :
                    sel_tcon ? tcon : systick;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            en      <= 1'b0;
            ie      <= 1'b0;
            status  <= 1'b0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_th) th <= Write_data;
            tl <= wr_tl ? Write_data : ovf ? th : tick ? tl + 32'd1 : tl;
            if (wr_tcon) begin
                en <= Write_data[TCON_EN];
                ie <= Write_data[TCON_IE];
            end
            status <= set_st || (wr_tcon ? Write_data[TCON_STATUS] : status);
        end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: PRESCALE=1 and PRESCALE=4 timers on one bus, checked against a behavioural model
module tb_mmio_timer;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE, A_TL = BASE + 32'd4, A_TC = BASE + 32'd8, A_ST = BASE + 32'd20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, Write_data;
    logic        MemRead, MemWrite;
    logic [31:0] rd1, rd4;
    logic        hit1, hit4, irq1, irq4;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_th[2], m_tl[2], m_sys[2];
    bit          m_en[2], m_ie[2], m_st[2];
    int          m_pc[2];
    logic [31:0] s_rd1, s_rd4;
    logic        s_hit1;

    always #5 clk = ~clk;

    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rd1), .hit(hit1), .IRQ(irq1)
    );
    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rd4), .hit(hit4), .IRQ(irq4)
    );

    task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (P=%0d) got %h expected %h at %0t", name, p, act, exp, $time);
        end
    endtask

    function automatic int presc(input int k);
        return k == 0 ? 1 : 4;
    endfunction

    function automatic bit m_hit(input logic [31:0] a, input bit acc);
        logic [31:0] off;
        off = a - BASE;
        return acc && off < 32 && a[1:0] == 2'b00 && (off == 0 || off == 4 || off == 8 || off == 20);
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off == 0) return m_th[k];
        if (off == 4) return m_tl[k];
        if (off == 8) return {29'b0, m_st[k], m_ie[k], m_en[k]};
        return m_sys[k];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_th[k] = 0; m_tl[k] = 0; m_sys[k] = 0;
            m_en[k] = 0; m_ie[k] = 0; m_st[k] = 0; m_pc[k] = 0;
        end
    endtask

    task automatic m_step(input int k);
        logic [31:0] off;
        bit w, w_tc, tick, set;
        off = Address - BASE;
        w = MemWrite && m_hit(Address, 1'b1);
        w_tc = w && off == 8;
        tick = 0;
        set = 0;
        if (m_en[k] && !(w_tc && !Write_data[0])) begin
            if (m_pc[k] == presc(k) - 1) begin
                tick = 1;
                m_pc[k] = 0;
            end else m_pc[k]++;
        end else m_pc[k] = 0;
        if (tick) begin
            if (m_tl[k] == 32'hFFFF_FFFF) begin
                m_tl[k] = m_th[k];
                set = m_ie[k] || (w_tc && Write_data[1]);
            end else m_tl[k] = m_tl[k] + 1;
        end
        if (w && off == 0) m_th[k] = Write_data;
        if (w && off == 4) m_tl[k] = Write_data;
        if (w_tc) begin
            m_en[k] = Write_data[0];
            m_ie[k] = Write_data[1];
            m_st[k] = Write_data[2];
        end
        if (set) m_st[k] = 1;
        m_sys[k] = m_sys[k] + 1;
    endtask

    // one bus cycle: drive just after posedge, compare at negedge, advance model at posedge
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit r, input bit w);
        bit he;
        Address = a; Write_data = d; MemRead = r; MemWrite = w;
        @(negedge clk);
        s_rd1 = rd1; s_rd4 = rd4; s_hit1 = hit1;
        he = m_hit(a, r || w);
        chk("hit", 1, 32'(hit1), 32'(he));
        chk("hit", 4, 32'(hit4), 32'(he));
        chk("rdata", 1, rd1, (r && he) ? m_read(0, a) : 32'h0);
        chk("rdata", 4, rd4, (r && he) ? m_read(1, a) : 32'h0);
        chk("irq", 1, 32'(irq1), 32'(m_ie[0] && m_st[0]));
        chk("irq", 4, 32'(irq4), 32'(m_ie[1] && m_st[1]));
        @(posedge clk);
        m_step(0);
        m_step(1);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(a, d, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(a, 32'h0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        bit          r;
        bit          w;
        bit          eh;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl[10];

    initial begin
        logic [31:0] v, a, d;
        int sel;
        tbl[0] = '{BASE + 32'h0C, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{BASE + 32'h09, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{32'h0000_0004, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{BASE + 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{BASE + 32'h16, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{BASE + 32'h0C, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[6] = '{A_TH, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0};
        tbl[7] = '{A_TC, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[8] = '{A_TL, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9] = '{BASE - 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};

        reset = 1'b0; Address = A_TL; Write_data = 0; MemRead = 1'b1; MemWrite = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tl", 1, rd1, 32'h0);
        chk("reset_irq", 1, 32'(irq1), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(A_ST);
            chk("systick_start", 1, s_rd1, 32'(i));
        end

        // overflow reload
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'h3);
        rd(A_TL);
        chk("tl_pre", 1, s_rd1, 32'hFFFF_FFFE);
        rd(A_TL);
        chk("tl_max", 1, s_rd1, 32'hFFFF_FFFF);
        chk("irq_reload", 1, 32'(irq1), 32'h1);
        rd(A_TL);
        chk("tl_reloaded", 1, s_rd1, 32'hFFFF_FFF0);

        // status clear, then clear aligned with overflow
        wr(A_TC, 32'h3);
        chk("irq_cleared", 1, 32'(irq1), 32'h0);
        wr(A_TL, 32'hFFFF_FFFE);
        rd(A_TL);
        wr(A_TC, 32'h3);
        chk("irq_set_wins", 1, 32'(irq1), 32'h1);
        rd(A_TC);
        chk("tcon_set_wins", 1, s_rd1, 32'h7);

        // prescaler on the PRESCALE=4 instance
        wr(A_TC, 32'h0);
        wr(A_TL, 32'h0);
        wr(A_TC, 32'h1);
        repeat (4) rd(A_TC);
        rd(A_TL);
        chk("presc_tl1", 4, s_rd4, 32'h1);
        repeat (3) rd(A_TC);
        rd(A_TL);
        chk("presc_tl2", 4, s_rd4, 32'h2);
        wr(A_TC, 32'h0);
        repeat (6) rd(A_TC);
        rd(A_TL);
        chk("presc_frozen", 4, s_rd4, 32'h2);

        // address decode table
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].w);
            chk("tbl_hit", 1, 32'(s_hit1), 32'(tbl[i].eh));
            chk("tbl_data", 1, s_rd1, tbl[i].ed);
        end
        rd(A_ST);
        v = s_rd1;
        wr(A_ST, 32'h1234);
        rd(A_ST);
        chk("systick_ro", 1, s_rd1, v + 32'd2);

        // TL write beats a coincident tick
        wr(A_TC, 32'h1);
        wr(A_TL, 32'h55);
        rd(A_TL);
        chk("tl_write_wins", 1, s_rd1, 32'h55);
        rd(A_TL);
        chk("tl_after_write", 1, s_rd1, 32'h56);

        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 7));
            d = $urandom;
            a = sel == 0 ? A_TH : sel == 1 ? A_TL : sel == 2 ? A_TC : sel == 3 ? A_ST :
                sel == 4 ? BASE + 32'h0C : sel == 5 ? BASE + 32'($urandom_range(0, 31)) :
                sel == 6 ? $urandom : A_TL;
            if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | (d & 32'hF);
            cycle(a, d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        // asynchronous reset mid-count
        wr(A_TC, 32'h7);
        chk("irq_before_reset", 1, 32'(irq1), 32'h1);
        #2;
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Address = A_TL;
        #1;
        chk("async_irq", 1, 32'(irq1), 32'h0);
        chk("async_irq", 4, 32'(irq4), 32'h0);
        chk("async_tl", 1, rd1, 32'h0);
        Address = A_TC;
        #1;
        chk("async_tcon", 1, rd1, 32'h0);
        Address = A_ST;
        #1;
        chk("async_systick", 4, rd4, 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(A_ST);
            chk("systick_restart", 1, s_rd1, 32'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
